// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : Architectural register file with DEPTH x N storage, one
//            synchronous write port, two combinational read ports with
//            optional same-cycle write bypass, optional hardwired zero entry
//            and a per-entry pending-write scoreboard (reserve at decode,
//            clear at writeback).
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int N        = 24,
  parameter int DEPTH    = 16,
  parameter int A        = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  // read port 1
  input  logic [A-1:0] RA1,
  output logic [N-1:0] RD1,
  output logic         Busy1,
  // read port 2
  input  logic [A-1:0] RA2,
  output logic [N-1:0] RD2,
  output logic         Busy2,
  // write port
  input  logic [A-1:0] WA3,
  input  logic [N-1:0] WD3,
  input  logic         WE3,
  // scoreboard reservation
  input  logic         ResEn,
  input  logic [A-1:0] ResAddr
);

  // DEPTH expressed with one spare bit so that an A-bit address can be
  // compared against it without overflow (DEPTH may equal 2**A).
  localparam logic [A:0] c_DEPTH_EXT = (A+1)'(DEPTH);
  localparam int         c_PORTS     = 2;

  // --------------------------------------------------------------------------
  // Address qualification
  // --------------------------------------------------------------------------

  // True when the address names a physical entry.
  function automatic logic f_in_range(input logic [A-1:0] addr);
    return ({1'b0, addr} < c_DEPTH_EXT);
  endfunction

  // True when the address names an entry that can be written or reserved:
  // in range and not the hardwired zero entry.
  function automatic logic f_addr_live(input logic [A-1:0] addr);
    return f_in_range(addr) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  logic w_wr_ok;
  logic w_res_ok;

  // Effective write / reserve strobes after address suppression. The write
  // strobe ignores rst on purpose: the bypass path keeps forwarding WD3
  // during reset, while the storage itself is held clear by the async reset.
  assign w_wr_ok  = WE3   && f_addr_live(WA3);
  assign w_res_ok = ResEn && f_addr_live(ResAddr);

  // --------------------------------------------------------------------------
  // Storage: one data word and one pending bit per entry
  // --------------------------------------------------------------------------
  logic [N-1:0] w_entry_data [DEPTH];
  logic         w_entry_pend [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if ((ZERO_REG != 0) && (i == 0)) begin : g_hardwired
        // Entry 0 has no storage; it always reads as zero and never busy.
        assign w_entry_data[i] = '0;
        assign w_entry_pend[i] = 1'b0;
      end else begin : g_stored
        localparam logic [A-1:0] c_IDX = A'(i);

        logic         w_wr_hit;
        logic         w_res_hit;
        logic [N-1:0] data_q;
        logic [N-1:0] data_d;
        logic         pend_q;
        logic         pend_d;

        assign w_wr_hit  = w_wr_ok  && (WA3     == c_IDX);
        assign w_res_hit = w_res_ok && (ResAddr == c_IDX);

        // Next state: a write stores data and retires the pending write; a
        // reserve on the same edge marks a new producer, so it wins.
        always_comb begin
          data_d = data_q;
          pend_d = pend_q;
          if (w_wr_hit) begin
            data_d = WD3;
            pend_d = 1'b0;
          end
          if (w_res_hit) begin
            pend_d = 1'b1;
          end
        end

        // Entry state register; reset clears data and pending immediately.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
          end else begin
            data_q <= data_d;
            pend_q <= pend_d;
          end
        end

        assign w_entry_data[i] = data_q;
        assign w_entry_pend[i] = pend_q;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [A-1:0] w_ra   [c_PORTS];
  logic [N-1:0] w_rd   [c_PORTS];
  logic         w_busy [c_PORTS];

  assign w_ra[0] = RA1;
  assign w_ra[1] = RA2;

  generate
    for (genvar p = 0; p < c_PORTS; p++) begin : g_read
      // Read priority: unreadable address -> zero; matching live write with
      // bypass -> forwarded data (value is now known, so not busy);
      // otherwise the stored entry and its pending bit.
      always_comb begin
        w_rd[p]   = '0;
        w_busy[p] = 1'b0;
        if (!f_addr_live(w_ra[p])) begin
          w_rd[p]   = '0;
          w_busy[p] = 1'b0;
        end else if ((BYPASS != 0) && w_wr_ok && (WA3 == w_ra[p])) begin
          w_rd[p]   = WD3;
          w_busy[p] = 1'b0;
        end else begin
          w_rd[p]   = w_entry_data[w_ra[p]];
          w_busy[p] = w_entry_pend[w_ra[p]];
        end
      end
    end
  endgenerate

  assign RD1   = w_rd[0];
  assign RD2   = w_rd[1];
  assign Busy1 = w_busy[0];
  assign Busy2 = w_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file. Three instances share the
//            same stimulus: default (bypass, zero reg), no-bypass, and a
//            non-power-of-two depth of 12 for out-of-range addressing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  localparam int N = 24;
  localparam int A = 4;

  logic         clk;
  logic         rst;
  logic [A-1:0] ra1, ra2, wa3, res_addr;
  logic [N-1:0] wd3;
  logic         we3, res_en;

  logic [N-1:0] m_rd1, m_rd2, nb_rd1, nb_rd2, o_rd1, o_rd2;
  logic         m_b1, m_b2, nb_b1, nb_b2, o_b1, o_b2;

  register_file #(.N(N), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) u_main (
    .clk(clk), .rst(rst),
    .RA1(ra1), .RD1(m_rd1), .Busy1(m_b1),
    .RA2(ra2), .RD2(m_rd2), .Busy2(m_b2),
    .WA3(wa3), .WD3(wd3), .WE3(we3),
    .ResEn(res_en), .ResAddr(res_addr)
  );

  register_file #(.N(N), .DEPTH(16), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst),
    .RA1(ra1), .RD1(nb_rd1), .Busy1(nb_b1),
    .RA2(ra2), .RD2(nb_rd2), .Busy2(nb_b2),
    .WA3(wa3), .WD3(wd3), .WE3(we3),
    .ResEn(res_en), .ResAddr(res_addr)
  );

  register_file #(.N(N), .DEPTH(12), .ZERO_REG(1), .BYPASS(1)) u_oor (
    .clk(clk), .rst(rst),
    .RA1(ra1), .RD1(o_rd1), .Busy1(o_b1),
    .RA2(ra2), .RD2(o_rd2), .Busy2(o_b2),
    .WA3(wa3), .WD3(wd3), .WE3(we3),
    .ResEn(res_en), .ResAddr(res_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: which output pair to look at and what it must show.
  // sel: 0 main p1, 1 main p2, 2 nobyp p1, 3 oor p1, 4 oor p2, 5 nobyp p2
  typedef struct {
    string        name;
    int           sel;
    logic [N-1:0] rd;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // One cycle of table stimulus plus the outputs expected before its edge.
  typedef struct {
    logic [A-1:0] ra1, ra2;
    logic         we;
    logic [A-1:0] wa;
    logic [N-1:0] wd;
    logic         res;
    logic [A-1:0] raddr;
    logic [N-1:0] rd1, rd2;
    logic         b1, b2;
    logic [N-1:0] nb_rd1;
    logic         nb_b1;
  } vec_t;

  localparam int c_NVEC = 18;
  vec_t tbl [c_NVEC];

  function automatic vec_t mk(
    input logic [A-1:0] r1, input logic [A-1:0] r2,
    input logic we, input logic [A-1:0] wa, input logic [N-1:0] wd,
    input logic res, input logic [A-1:0] raddr,
    input logic [N-1:0] e1, input logic [N-1:0] e2,
    input logic eb1, input logic eb2,
    input logic [N-1:0] enb1, input logic enbb1);
    vec_t v;
    v.ra1 = r1; v.ra2 = r2; v.we = we; v.wa = wa; v.wd = wd;
    v.res = res; v.raddr = raddr;
    v.rd1 = e1; v.rd2 = e2; v.b1 = eb1; v.b2 = eb2;
    v.nb_rd1 = enb1; v.nb_b1 = enbb1;
    return v;
  endfunction

  task automatic drive(input logic [A-1:0] r1, input logic [A-1:0] r2,
                       input logic we, input logic [A-1:0] wa,
                       input logic [N-1:0] wd, input logic res,
                       input logic [A-1:0] raddr);
    ra1 = r1; ra2 = r2; we3 = we; wa3 = wa; wd3 = wd;
    res_en = res; res_addr = raddr;
  endtask

  task automatic expect_out(input string name, input int sel,
                            input logic [N-1:0] rd, input logic busy);
    exp_t e;
    e.name = name; e.sel = sel; e.rd = rd; e.busy = busy;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare against the live outputs.
  task automatic drain();
    exp_t         e;
    logic [N-1:0] a_rd;
    logic         a_b;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin a_rd = m_rd1;  a_b = m_b1;  end
        1:       begin a_rd = m_rd2;  a_b = m_b2;  end
        2:       begin a_rd = nb_rd1; a_b = nb_b1; end
        3:       begin a_rd = o_rd1;  a_b = o_b1;  end
        4:       begin a_rd = o_rd2;  a_b = o_b2;  end
        default: begin a_rd = nb_rd2; a_b = nb_b2; end
      endcase
      checks++;
      if (a_rd !== e.rd || a_b !== e.busy) begin
        failures++;
        $display("FAIL %s: got rd=%h busy=%b, expected rd=%h busy=%b",
                 e.name, a_rd, a_b, e.rd, e.busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ra1 ra2 we wa   wd          res raddr  rd1         rd2         b1 b2 nb_rd1      nb_b1
    tbl[0]  = mk(0,  0,  0, 0,  24'h000000, 0, 0,     24'h000000, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[1]  = mk(5,  0,  1, 5,  24'h011111, 0, 0,     24'h011111, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[2]  = mk(5,  5,  1, 5,  24'h0AAAAA, 0, 0,     24'h0AAAAA, 24'h0AAAAA, 0, 0, 24'h011111, 0);
    tbl[3]  = mk(5,  3,  0, 0,  24'h000000, 0, 0,     24'h0AAAAA, 24'h000000, 0, 0, 24'h0AAAAA, 0);
    tbl[4]  = mk(0,  0,  1, 0,  24'hFFFFFF, 0, 0,     24'h000000, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[5]  = mk(0,  0,  0, 0,  24'h000000, 1, 0,     24'h000000, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[6]  = mk(0,  0,  0, 0,  24'h000000, 0, 0,     24'h000000, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[7]  = mk(7,  7,  1, 7,  24'h044444, 0, 0,     24'h044444, 24'h044444, 0, 0, 24'h000000, 0);
    tbl[8]  = mk(7,  5,  0, 0,  24'h000000, 0, 0,     24'h044444, 24'h0AAAAA, 0, 0, 24'h044444, 0);
    tbl[9]  = mk(3,  3,  0, 0,  24'h000000, 1, 3,     24'h000000, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[10] = mk(3,  3,  1, 3,  24'h077777, 0, 0,     24'h077777, 24'h077777, 0, 0, 24'h000000, 1);
    tbl[11] = mk(3,  3,  0, 0,  24'h000000, 0, 0,     24'h077777, 24'h077777, 0, 0, 24'h077777, 0);
    tbl[12] = mk(3,  10, 1, 3,  24'h077777, 1, 3,     24'h077777, 24'h000000, 0, 0, 24'h077777, 0);
    tbl[13] = mk(3,  3,  0, 0,  24'h000000, 0, 0,     24'h077777, 24'h077777, 1, 1, 24'h077777, 1);
    tbl[14] = mk(10, 11, 1, 11, 24'h123456, 1, 10,    24'h000000, 24'h123456, 0, 0, 24'h000000, 0);
    tbl[15] = mk(10, 11, 0, 0,  24'h000000, 0, 0,     24'h000000, 24'h123456, 1, 0, 24'h000000, 1);
    tbl[16] = mk(15, 14, 1, 15, 24'hFFFFFF, 0, 0,     24'hFFFFFF, 24'h000000, 0, 0, 24'h000000, 0);
    tbl[17] = mk(15, 15, 0, 0,  24'h000000, 0, 0,     24'hFFFFFF, 24'hFFFFFF, 0, 0, 24'hFFFFFF, 0);

    // Asynchronous reset before any clock edge has occurred.
    rst = 1'b0;
    drive(5, 9, 0, 0, '0, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst.main1", 0, '0, 1'b0);
    expect_out("async_rst.main2", 1, '0, 1'b0);
    expect_out("async_rst.nb1",   2, '0, 1'b0);
    expect_out("async_rst.nb2",   5, '0, 1'b0);
    expect_out("async_rst.oor1",  3, '0, 1'b0);
    expect_out("async_rst.oor2",  4, '0, 1'b0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors; outputs checked before each edge.
    for (int i = 0; i < c_NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].res, tbl[i].raddr);
      expect_out($sformatf("row%0d.main1", i), 0, tbl[i].rd1, tbl[i].b1);
      expect_out($sformatf("row%0d.main2", i), 1, tbl[i].rd2, tbl[i].b2);
      expect_out($sformatf("row%0d.nb1", i),   2, tbl[i].nb_rd1, tbl[i].nb_b1);
      #2;
      drain();
    end

    // Reset mid-operation: reserve and write r9 on one edge, then reset.
    @(negedge clk);
    drive(9, 9, 1, 9, 24'h022222, 1, 9);
    expect_out("midrst.setup.main1", 0, 24'h022222, 1'b0);
    expect_out("midrst.setup.nb1",   2, 24'h000000, 1'b0);
    #2 drain();
    @(negedge clk);
    drive(9, 9, 0, 0, '0, 0, 0);
    expect_out("midrst.before.main1", 0, 24'h022222, 1'b1);
    expect_out("midrst.before.nb1",   2, 24'h022222, 1'b1);
    #2 drain();
    #1 rst = 1'b1;
    #1;
    expect_out("midrst.now.main1", 0, '0, 1'b0);
    expect_out("midrst.now.main2", 1, '0, 1'b0);
    expect_out("midrst.now.nb1",   2, '0, 1'b0);
    drain();
    @(negedge clk);
    drive(9, 4, 1, 9, 24'h333333, 1, 9);
    expect_out("midrst.bypass.main1", 0, 24'h333333, 1'b0);
    expect_out("midrst.bypass.main2", 1, '0, 1'b0);
    expect_out("midrst.bypass.nb1",   2, '0, 1'b0);
    #2 drain();
    @(negedge clk);
    rst = 1'b0;
    drive(9, 9, 0, 0, '0, 0, 0);
    expect_out("midrst.after.main1", 0, '0, 1'b0);
    expect_out("midrst.after.nb1",   2, '0, 1'b0);
    #2 drain();

    // Out-of-range write and reserve on the depth-12 instance.
    @(negedge clk);
    drive(13, 13, 1, 13, 24'h0EEEEE, 0, 0);
    expect_out("oor.wr.oor1",  3, '0, 1'b0);
    expect_out("oor.wr.main1", 0, 24'h0EEEEE, 1'b0);
    #2 drain();
    @(negedge clk);
    drive(13, 13, 0, 0, '0, 1, 13);
    expect_out("oor.res.oor1",  3, '0, 1'b0);
    expect_out("oor.res.main1", 0, 24'h0EEEEE, 1'b0);
    #2 drain();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(A'(k), 13, 0, 0, '0, 0, 0);
      expect_out($sformatf("oor.scan%0d.oor1", k), 3, '0, 1'b0);
      expect_out($sformatf("oor.scan%0d.main1", k), 0, '0, 1'b0);
      if (k == 0) begin
        expect_out("oor.scan.oor2",  4, '0, 1'b0);
        expect_out("oor.scan.main2", 1, 24'h0EEEEE, 1'b1);
      end
      #2 drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Parametrised multi-entry successor to the processor's single `register` block. It holds DEPTH words of N bits, with:
- one synchronous write port;
- two asynchronous read ports with optional same-cycle write bypass;
- an optional hardwired zero entry;
- a per-entry pending-write scoreboard.

It is the architectural register file of the pipeline, between decode (read/reserve) and writeback (write).

## Interface
- N, 24, data width in bits
- DEPTH, 16, number of entries (≥2, need not be a power of 2)
- A, $clog2(DEPTH), address width (derived)
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes and reservations
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- RA1  in  A  read address, port 1
- RA2  in  A  read address, port 2
- RD1  out  N  read data, port 1 (combinational)
- RD2  out  N  read data, port 2 (combinational)
- WA3  in  A  write address
- WD3  in  N  write data
- WE3  in  1  write enable
- ResEn  in  1  reserve enable (mark entry pending)
- ResAddr  in  A  entry to reserve
- Busy1  out  1  entry RA1 has a pending write (combinational)
- Busy2  out  1  entry RA2 has a pending write (combinational)

## Operation
- Storage: DEPTH×N data array plus DEPTH pending bits.
- Write: at rising clk with WE3=1, entry[WA3] ← WD3 and pending[WA3] ← 0. Suppressed when WA3 ≥ DEPTH, or when WA3=0 with ZERO_REG=1.
- Reserve: at rising clk with ResEn=1, pending[ResAddr] ← 1. Suppressed under the same address rules as write.
- Simultaneous write and reserve, same address: write data is stored and pending ends at 1 (reserve wins; new producer).
- Simultaneous write and reserve, different addresses: both take effect independently.
- Read (port p = 1, 2), in priority order:
  1. RAp ≥ DEPTH, or RAp=0 with ZERO_REG=1 → RDp=0, Busyp=0.
  2. BYPASS=1, WE3=1 and WA3==RAp (write not suppressed) → RDp=WD3, Busyp=0.
  3. Otherwise → RDp=entry[RAp], Busyp=pending[RAp].
- Both read ports are fully independent; RA1==RA2 is legal and yields identical outputs.
- With BYPASS=0, reads show old data and old pending until the write edge.
- No arithmetic; widths are exact: N-bit data, A-bit addresses, no truncation or extension.

## Timing
- Write and reserve latency: 1 clk edge. With BYPASS=1, read-after-write is visible in the same cycle.
- Read latency: 0 (combinational from RAp, array state and, when BYPASS=1, WE3/WA3/WD3).
- Reset:
  - Asserting rst immediately (no clock needed) clears all entries to 0 and all pending bits to 0.
  - While rst=1, writes and reserves are ignored. RDp reads 0 except through the bypass path (BYPASS=1 still forwards WD3 combinationally). Busy1=Busy2=0.
  - Release is synchronous-safe: the first edge with rst=0 performs the normal write/reserve.
- Reset mid-operation: a pending bit set the previous cycle is lost. Any in-flight write on the asserting edge is discarded.
- Outputs after reset with idle inputs: RD1=RD2=0, Busy1=Busy2=0.

## Test plan
All scenarios use N=24, DEPTH=16, ZERO_REG=1, BYPASS=1 unless stated.
1. Reset and basic write/read:
   - Pulse rst between edges → RD1=RD2=0 without a clock edge.
   - Write 24'h11111 to r5 → after the edge, RA1=5 gives RD1=24'h11111.
   - Write 24'hAAAAA to r5 → after the next edge, RD1=24'hAAAAA.
2. Zero register: WE3=1, WA3=0, WD3=24'hFFFFFF, then RA1=RA2=0 → RD1=RD2=0 and Busy1=0 in the write cycle and after it. ResEn to r0 → Busy1 stays 0.
3. Bypass:
   - Same cycle: WE3=1, WA3=7, WD3=24'h44444, RA1=RA2=7 → RD1=RD2=24'h44444 before the edge.
   - Repeat with BYPASS=0 → RD1 shows the old r7 until the edge, 24'h44444 after.
4. Scoreboard:
   - ResEn, ResAddr=3 → after the edge, Busy1=1 for RA1=3.
   - Next cycle write r3=24'h77777 → Busy1=0 in that cycle (bypass) and after the edge.
   - Reserve and write r3 on the same edge → stored 24'h77777, Busy1=1 afterwards.
5. Reset mid-operation: reserve r9 and write r9=24'h22222, then assert rst before the next edge → Busy1=0 and RD1=0 immediately. A write presented on the edge while rst=1 is not stored.
6. Out-of-range (DEPTH=12): write 24'hEEEEE to address 13 → no entry changes, and RA1=13 gives RD1=0, Busy1=0.
